// File: rtl/param_stack.sv
// rtl/param_stack.sv - parametrised LIFO stack with replace-top, empty bypass, flush and sticky errors
//
// Ports:
//   clk          in   rising-edge clock
//   rstn         in   synchronous active-low reset
//   data_in      in   word to push
//   push, pop    in   requests; both together replace the top (or bypass when empty)
//   flush        in   discard all entries
//   clr_err      in   clear overflow/underflow
//   data_out     out  registered popped word, held until the next pop
//   data_valid   out  one-cycle strobe after a successful pop
//   top          out  combinational peek of the top entry, 0 when empty
//   level        out  current entry count
//   full, empty, almost_full, almost_empty  out  derived from level
//   overflow, underflow                    out  sticky error flags
module param_stack #(
  parameter int WORD_LEN    = 8,
  parameter int STACK_DEPTH = 8,
  parameter int AF_THRESH   = STACK_DEPTH - 1,
  parameter int AE_THRESH   = 1
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [WORD_LEN-1:0]              data_in,
  input  logic                             push,
  input  logic                             pop,
  input  logic                             flush,
  input  logic                             clr_err,
  output logic [WORD_LEN-1:0]              data_out,
  output logic                             data_valid,
  output logic [WORD_LEN-1:0]              top,
  output logic [$clog2(STACK_DEPTH+1)-1:0] level,
  output logic                             full,
  output logic                             empty,
  output logic                             almost_full,
  output logic                             almost_empty,
  output logic                             overflow,
  output logic                             underflow
);

  localparam int LW = $clog2(STACK_DEPTH + 1);
  localparam int AW = $clog2(STACK_DEPTH);

  logic [WORD_LEN-1:0] r_mem [STACK_DEPTH];
  logic [LW-1:0]       r_level;
  logic [WORD_LEN-1:0] r_data_out;
  logic                r_data_valid;
  logic                r_overflow;
  logic                r_underflow;

  logic                w_full;
  logic                w_empty;
  logic [LW-1:0]       w_level_m1;
  logic [AW-1:0]       w_wr_idx;
  logic [AW-1:0]       w_top_idx;

  assign w_full     = (r_level == LW'(STACK_DEPTH));
  assign w_empty    = (r_level == '0);
  assign w_level_m1 = r_level - LW'(1);
  // Index slices are only used when the guarding full/empty test passes,
  // so the truncated value is always in range.
  assign w_wr_idx   = r_level[AW-1:0];
  assign w_top_idx  = w_level_m1[AW-1:0];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_level      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      // Clear first so that an error event later in this block wins the race.
      if (clr_err) begin
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end
      if (flush) begin
        r_level <= '0;
      end else begin
        case ({push, pop})
          2'b10: begin
            if (!w_full) begin
              r_mem[w_wr_idx] <= data_in;
              r_level         <= r_level + LW'(1);
            end else begin
              r_overflow <= 1'b1;
            end
          end
          2'b01: begin
            if (!w_empty) begin
              r_data_out   <= r_mem[w_top_idx];
              r_data_valid <= 1'b1;
              r_level      <= w_level_m1;
            end else begin
              r_underflow <= 1'b1;
            end
          end
          2'b11: begin
            if (!w_empty) begin
              r_data_out       <= r_mem[w_top_idx];
              r_data_valid     <= 1'b1;
              r_mem[w_top_idx] <= data_in;
            end else begin
              // Empty bypass: the pushed word goes straight to the consumer.
              r_data_out   <= data_in;
              r_data_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign data_out     = r_data_out;
  assign data_valid   = r_data_valid;
  assign top          = w_empty ? '0 : r_mem[w_top_idx];
  assign level        = r_level;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_level >= LW'(AF_THRESH));
  assign almost_empty = (r_level <= LW'(AE_THRESH));
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_param_stack.sv
// tb/tb_param_stack.sv - directed self-checking bench for param_stack
module tb_param_stack;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int LW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rstn;
  logic [W-1:0]  data_in;
  logic          push, pop, flush, clr_err;
  logic [W-1:0]  data_out;
  logic          data_valid;
  logic [W-1:0]  top;
  logic [LW-1:0] level;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;

  int total = 0;
  int bad   = 0;

  param_stack #(
    .WORD_LEN(W), .STACK_DEPTH(D), .AF_THRESH(3), .AE_THRESH(1)
  ) dut (
    .clk(clk), .rstn(rstn), .data_in(data_in), .push(push), .pop(pop),
    .flush(flush), .clr_err(clr_err), .data_out(data_out),
    .data_valid(data_valid), .top(top), .level(level), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic op(input logic p, input logic q, input logic f,
                    input logic c, input logic [W-1:0] d);
    push = p; pop = q; flush = f; clr_err = c; data_in = d;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0; data_in = '0;
  endtask

  logic [W-1:0] drain_exp [4];

  initial begin
    drain_exp[0] = 8'h44; drain_exp[1] = 8'h33;
    drain_exp[2] = 8'h22; drain_exp[3] = 8'h11;
    rstn = 1'b1; push = 0; pop = 0; flush = 0; clr_err = 0; data_in = '0;

    // Random activity, then hold reset for two clocks.
    for (int i = 0; i < 6; i++)
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
         1'b0, W'($urandom));
    rstn = 1'b0;
    op(1, 0, 0, 0, 8'hEE);
    op(0, 1, 0, 0, 8'h00);
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_top", top, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_dv", data_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    rstn = 1'b1;

    // Fill and overflow.
    op(1, 0, 0, 0, 8'h11);
    op(1, 0, 0, 0, 8'h22);
    chk("fill2_af", almost_full, 0);
    chk("fill2_ae", almost_empty, 0);
    op(1, 0, 0, 0, 8'h33);
    chk("fill3_af", almost_full, 1);
    chk("fill3_level", level, 3);
    op(1, 0, 0, 0, 8'h44);
    chk("fill4_full", full, 1);
    chk("fill4_level", level, 4);
    chk("fill4_top", top, 8'h44);
    op(1, 0, 0, 0, 8'h55);
    chk("ovf_level", level, 4);
    chk("ovf_top", top, 8'h44);
    chk("ovf_flag", overflow, 1);
    op(0, 0, 0, 1, 8'h00);
    chk("ovf_clr", overflow, 0);

    // Drain and underflow.
    for (int i = 0; i < 4; i++) begin
      op(0, 1, 0, 0, 8'h00);
      chk("drain_dout", data_out, drain_exp[i]);
      chk("drain_dv", data_valid, 1);
      chk("drain_level", level, 3 - i);
    end
    op(0, 0, 0, 0, 8'h00);
    chk("drain_dv_idle", data_valid, 0);
    chk("drain_empty", empty, 1);
    op(0, 1, 0, 0, 8'h00);
    chk("udf_dv", data_valid, 0);
    chk("udf_dout", data_out, 8'h11);
    chk("udf_flag", underflow, 1);
    op(0, 0, 0, 1, 8'h00);
    chk("udf_clr", underflow, 0);

    // Replace-top.
    op(1, 0, 0, 0, 8'hA0);
    op(1, 0, 0, 0, 8'hB0);
    op(1, 1, 0, 0, 8'hC0);
    chk("rt_dout", data_out, 8'hB0);
    chk("rt_dv", data_valid, 1);
    chk("rt_level", level, 2);
    chk("rt_top", top, 8'hC0);
    op(1, 0, 0, 0, 8'hD0);
    op(1, 0, 0, 0, 8'hE0);
    op(1, 1, 0, 0, 8'hF0);
    chk("rtf_level", level, 4);
    chk("rtf_ovf", overflow, 0);
    chk("rtf_dout", data_out, 8'hE0);
    chk("rtf_top", top, 8'hF0);

    // Flush to empty, then bypass.
    op(0, 0, 1, 0, 8'h00);
    chk("fl_level", level, 0);
    chk("fl_dout", data_out, 8'hE0);
    op(1, 1, 0, 0, 8'h5A);
    chk("byp_dout", data_out, 8'h5A);
    chk("byp_dv", data_valid, 1);
    chk("byp_level", level, 0);
    chk("byp_udf", underflow, 0);
    op(1, 0, 0, 0, 8'h01);
    op(1, 0, 0, 0, 8'h02);
    op(1, 0, 0, 0, 8'h03);
    chk("pre_fl_level", level, 3);
    op(1, 1, 1, 0, 8'h99);
    chk("flpp_level", level, 0);
    chk("flpp_dv", data_valid, 0);
    chk("flpp_dout", data_out, 8'h5A);
    chk("flpp_top", top, 0);

    // Error set/clear race.
    op(0, 1, 0, 1, 8'h00);
    chk("race_udf", underflow, 1);

    // Mid-operation reset.
    op(0, 0, 0, 1, 8'h00);
    op(1, 0, 0, 0, 8'h71);
    op(1, 0, 0, 0, 8'h72);
    chk("mr_pre_level", level, 2);
    rstn = 1'b0;
    op(1, 0, 0, 0, 8'h73);
    chk("mr_level", level, 0);
    chk("mr_top", top, 0);
    rstn = 1'b1;
    op(1, 0, 0, 0, 8'h81);
    chk("mr_after_level", level, 1);
    chk("mr_after_top", top, 8'h81);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
